// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW result streamer.
// FIFO entry layout is {qid, position, minval} from MSB to LSB.
package dtw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        BEAT0,
        BEAT1,
        BEAT2
    } state_t;

    localparam logic [31:0] TERM_QID = 32'hFFFF_FFFF;

    localparam int QID_LSB = 48;
    localparam int POS_LSB = 16;
    localparam int MIN_LSB = 0;

endpackage

// File: rtl/dtw_result_streamer_if.sv
// AXI-Stream beat channel between the result streamer and the S2MM DMA.
interface dtw_result_streamer_if #(
    parameter int DW = 32
);

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/dtw_result_streamer.sv
// Drains the DTW sink FIFO and serialises {qid, position, minval} records
// as three-beat AXI-Stream words, grouped into packets of pkt_len records.
module dtw_result_streamer
    import dtw_pkg::*;
#(
    parameter int DTW_DWIDTH = 16,
    parameter int AXI_DWIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [CNT_WIDTH-1:0]      pkt_len,
    input  logic                      flush,
    input  logic                      fifo_empty,
    output logic                      fifo_rden,
    input  logic [64+DTW_DWIDTH-1:0]  fifo_dout,
    dtw_result_streamer_if.master     m_axis,
    output logic                      busy,
    output logic [31:0]               records_sent
);

    state_t                state;
    state_t                nxt;
    logic [31:0]           qid;
    logic [31:0]           pos;
    logic [DTW_DWIDTH-1:0] minval;
    logic                  is_term;
    logic [CNT_WIDTH-1:0]  rec_cnt;
    logic [CNT_WIDTH-1:0]  eff_len;
    logic                  last_rec;
    logic                  load_term;
    logic                  beat2_done;

    // Terminators always close the packet regardless of eff_len.
    assign last_rec = is_term ||
        (({1'b0, rec_cnt} + 1'b1) == {1'b0, eff_len});

    assign beat2_done = (state == BEAT2) && m_axis.tready;
    assign busy       = (state != IDLE);

    always_comb begin
        nxt           = state;
        load_term     = 1'b0;
        fifo_rden     = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tlast  = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    nxt = FETCH;
                end else if (flush && (rec_cnt != '0)) begin
                    load_term = 1'b1;
                    nxt       = BEAT0;
                end
            end
            FETCH: begin
                fifo_rden = 1'b1;
                nxt       = CAPTURE;
            end
            CAPTURE: nxt = BEAT0;
            BEAT0: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = AXI_DWIDTH'(qid);
                if (m_axis.tready) nxt = BEAT1;
            end
            BEAT1: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = AXI_DWIDTH'(pos);
                if (m_axis.tready) nxt = BEAT2;
            end
            BEAT2: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = AXI_DWIDTH'(minval);
                m_axis.tlast  = last_rec;
                if (m_axis.tready) begin
                    nxt = (enable && !fifo_empty) ? FETCH : IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            qid          <= '0;
            pos          <= '0;
            minval       <= '0;
            is_term      <= 1'b0;
            rec_cnt      <= '0;
            eff_len      <= '0;
            records_sent <= '0;
        end else begin
            state <= nxt;
            if (load_term) begin
                qid     <= TERM_QID;
                pos     <= 32'(rec_cnt);
                minval  <= '0;
                is_term <= 1'b1;
            end
            if (state == CAPTURE) begin
                qid     <= fifo_dout[QID_LSB +: 32];
                pos     <= fifo_dout[POS_LSB +: 32];
                minval  <= fifo_dout[MIN_LSB +: DTW_DWIDTH];
                is_term <= 1'b0;
                if (rec_cnt == '0) begin
                    eff_len <= (pkt_len == '0) ? CNT_WIDTH'(1) : pkt_len;
                end
            end
            if (beat2_done) begin
                rec_cnt <= last_rec ? '0 : rec_cnt + 1'b1;
                if (!is_term) records_sent <= records_sent + 32'd1;
            end
        end
    end

endmodule
